// File: rtl/alzette_iter_unit.sv
// Alzette ARX-box engine: forward or inverse box in 4/UNROLL compute cycles,
// with valid/ready handshakes on both the request and the response side.
module alzette_iter_unit #(
    parameter int unsigned UNROLL = 1,
    parameter int unsigned INV_EN = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_inv,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [31:0] req_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_x,
    output logic [31:0] rsp_y
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // The counter is 2 bits, so it wraps modulo 4 and UNROLL=4 becomes a step of 0.
    localparam logic [1:0] FWD_LAST = 2'(4 - UNROLL);
    localparam logic [1:0] INV_LAST = 2'(UNROLL - 1);

    state_t      state;
    logic [31:0] x_q, y_q, c_q;
    logic        inv_q;
    logic [1:0]  ctr;
    logic [31:0] x_n, y_n;
    logic [1:0]  ctr_n;
    logic        last;
    logic        acc_inv;

    function automatic logic [4:0] rot_r(input logic [1:0] k);
        case (k)
            2'd0:    return 5'd31;
            2'd1:    return 5'd17;
            2'd2:    return 5'd0;
            default: return 5'd24;
        endcase
    endfunction

    function automatic logic [4:0] rot_s(input logic [1:0] k);
        case (k)
            2'd0:    return 5'd24;
            2'd1:    return 5'd17;
            2'd2:    return 5'd31;
            default: return 5'd16;
        endcase
    endfunction

    // A shift by 32 yields zero, so n=0 collapses to the identity.
    function automatic logic [31:0] ror(input logic [31:0] v, input logic [4:0] n);
        return (v >> n) | (v << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [63:0] fwd_round(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] c, input logic [1:0] k);
        logic [31:0] xa, yn;
        xa = x + ror(y, rot_r(k));
        yn = y ^ ror(xa, rot_s(k));
        return {xa ^ c, yn};
    endfunction

    function automatic logic [63:0] inv_round(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] c, input logic [1:0] k);
        logic [31:0] xa, yn;
        xa = x ^ c;
        yn = y ^ ror(xa, rot_s(k));
        return {xa - ror(yn, rot_r(k)), yn};
    endfunction

    always_comb begin
        x_n   = x_q;
        y_n   = y_q;
        ctr_n = ctr;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (inv_q) begin
                {x_n, y_n} = inv_round(x_n, y_n, c_q, ctr_n);
                ctr_n      = ctr_n - 2'd1;
            end else begin
                {x_n, y_n} = fwd_round(x_n, y_n, c_q, ctr_n);
                ctr_n      = ctr_n + 2'd1;
            end
        end
        last    = inv_q ? (ctr == INV_LAST) : (ctr == FWD_LAST);
        acc_inv = (INV_EN != 0) && req_inv;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            ctr       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            c_q       <= '0;
            inv_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        x_q       <= req_x;
                        y_q       <= req_y;
                        c_q       <= req_c;
                        inv_q     <= acc_inv;
                        ctr       <= acc_inv ? 2'd3 : 2'd0;
                        req_ready <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    x_q <= x_n;
                    y_q <= y_n;
                    ctr <= ctr_n;
                    if (last) begin
                        rsp_x     <= x_n;
                        rsp_y     <= y_n;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alzette_iter_unit.sv
// Scoreboard bench for alzette_iter_unit: one instance per UNROLL value (1, 2, 4),
// each with its own driver pushing expectations and a monitor popping them.
module tb_alzette_iter_unit;
    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned n);
        logic [31:0] r = v;
        for (int unsigned i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic logic [63:0] ref_fwd(input logic [31:0] x0, input logic [31:0] y0,
                                            input logic [31:0] c);
        int unsigned rr[4] = '{31, 17, 0, 24};
        int unsigned ss[4] = '{24, 17, 31, 16};
        logic [31:0] x = x0;
        logic [31:0] y = y0;
        for (int k = 0; k < 4; k++) begin
            x = x + rotr(y, rr[k]);
            y = y ^ rotr(x, ss[k]);
            x = x ^ c;
        end
        return {x, y};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int unsigned UN = 1 << g;
        localparam int LAT = 4 / UN + 1;

        logic        rstn, req_valid, req_ready, req_inv, rsp_valid, rsp_ready;
        logic [31:0] req_x, req_y, req_c, rsp_x, rsp_y;
        exp_t        q[$];
        bit          fin = 1'b0;

        alzette_iter_unit #(.UNROLL(UN), .INV_EN(1)) dut (
            .g_clk    (clk),
            .g_resetn (rstn),
            .req_valid(req_valid),
            .req_ready(req_ready),
            .req_inv  (req_inv),
            .req_x    (req_x),
            .req_y    (req_y),
            .req_c    (req_c),
            .rsp_valid(rsp_valid),
            .rsp_ready(rsp_ready),
            .rsp_x    (rsp_x),
            .rsp_y    (rsp_y)
        );

        task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL u%0d %s got %h want %h", UN, name, act, want);
            end
        endtask

        task automatic chk_reset_state(input string tag);
            chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
            chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
            chk({tag, "_rsp_x"}, rsp_x, 32'd0);
            chk({tag, "_rsp_y"}, rsp_y, 32'd0);
        endtask

        // junk > 0 keeps req_valid high with scrambled data during RUN.
        task automatic send(input logic inv, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] c, input logic [31:0] ex, input logic [31:0] ey,
                            input int junk, input bit expect_rsp);
            int t = 0;
            @(negedge clk);
            req_valid = 1'b1;
            req_inv   = inv;
            req_x     = x;
            req_y     = y;
            req_c     = c;
            while (!req_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!req_ready) begin
                checks++;
                errors++;
                $display("FAIL u%0d accept_timeout got ready=0 want ready=1", UN);
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            if (expect_rsp) q.push_back('{ex, ey, cyc});
            @(negedge clk);
            for (int j = 0; j < junk; j++) begin
                req_inv = ~inv;
                req_x   = $urandom;
                req_y   = $urandom;
                req_c   = $urandom;
                @(negedge clk);
            end
            req_valid = 1'b0;
        endtask

        initial begin : driver
            logic [31:0] rx, ry, rc;
            logic [63:0] f;
            int t;
            rstn = 1'b0; req_valid = 1'b0; req_inv = 1'b0;
            req_x = '0; req_y = '0; req_c = '0;
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            @(negedge clk);
            chk_reset_state("reset");

            send(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b1);
            send(1'b0, 32'h0, 32'h0, 32'h1, 32'h01808000, 32'h80008180, 0, 1'b1);
            send(1'b1, 32'h01808000, 32'h80008180, 32'h1, 32'h0, 32'h0, 0, 1'b1);
            send(1'b0, 32'h0, 32'h0, 32'h1, 32'h01808000, 32'h80008180, int'(4 / UN), 1'b1);
            send(1'b1, 32'h01808000, 32'h80008180, 32'h1, 32'h0, 32'h0, int'(4 / UN), 1'b1);

            // Abort a request in RUN; no response may follow it.
            send(1'b0, 32'hdeadbeef, 32'hcafef00d, 32'h1234abcd, 32'h0, 32'h0, 0, 1'b0);
            rstn = 1'b0;
            @(negedge clk);
            chk_reset_state("midrun_reset");
            rstn = 1'b1;
            send(1'b0, 32'h0, 32'h0, 32'h1, 32'h01808000, 32'h80008180, 0, 1'b1);

            for (int n = 0; n < 1000; n++) begin
                rx = $urandom; ry = $urandom; rc = $urandom;
                f  = ref_fwd(rx, ry, rc);
                send(1'b0, rx, ry, rc, f[63:32], f[31:0], 0, 1'b1);
                send(1'b1, f[63:32], f[31:0], rc, rx, ry, 0, 1'b1);
            end

            t = 0;
            while (q.size() != 0 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            chk("drain_pending", 32'(q.size()), 32'd0);
            fin = 1'b1;
        end

        initial begin : monitor
            exp_t e;
            logic [31:0] hx, hy;
            int stall;
            rsp_ready = 1'b0;
            forever begin
                @(negedge clk);
                if (rstn && rsp_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL u%0d unexpected_rsp got x=%h y=%h want no response",
                                 UN, rsp_x, rsp_y);
                    end else begin
                        e = q.pop_front();
                        chk("latency", 32'(cyc - e.acc), 32'(LAT));
                        chk("rsp_x", rsp_x, e.x);
                        chk("rsp_y", rsp_y, e.y);
                        hx = rsp_x;
                        hy = rsp_y;
                        stall = int'($urandom_range(0, 5));
                        for (int s = 0; s < stall; s++) begin
                            @(negedge clk);
                            chk("stall_valid", 32'(rsp_valid), 32'd1);
                            chk("stall_x", rsp_x, hx);
                            chk("stall_y", rsp_y, hy);
                        end
                    end
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                end
            end
        end
    end

    initial begin : summary
        int t = 0;
        while (!(u[0].fin && u[1].fin && u[2].fin) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        if (!(u[0].fin && u[1].fin && u[2].fin)) begin
            checks++;
            errors++;
            $display("FAIL global_timeout got unfinished drivers want all finished");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
